// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage owning the PC, registering ROM words into a valid/ready output slot.
// Optional JMP predecode enabled by defining FETCH_JMP_PREDECODE_EN.
module instr_fetch #(
    parameter int ADDR_WIDTH = 16,
    parameter int ROM_WIDTH = 21,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [ROM_WIDTH-1:0]  rom_data,
    output logic [ROM_WIDTH-1:0]  instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    input  logic                  halt_req,
    output logic                  halted
);
    typedef enum logic {RUN, HALT} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, instr_pc_q;
    logic [ROM_WIDTH-1:0]  instr_q;
    logic                  valid_q;
    logic                  fire, load;

    assign fire = valid_q & instr_ready;
    assign load = (state_q == RUN) & (!valid_q | instr_ready);

`ifdef FETCH_JMP_PREDECODE_EN
    // Unconditional JMP steers the PC at fetch time so the target follows with no bubble.
    assign pc_d = (rom_data[ROM_WIDTH-1 -: 5] == 5'b01001) ? ADDR_WIDTH'(rom_data[15:0]) : pc_q + 1'b1;
`else
    assign pc_d = pc_q + 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            state_q    <= RUN;
        end else if (redirect_valid) begin
            pc_q    <= redirect_addr;
            valid_q <= 1'b0;
            state_q <= RUN;
        end else if (state_q == RUN && halt_req) begin
            // Halting suppresses this cycle's load; a pending word still drains.
            state_q <= HALT;
            if (fire) valid_q <= 1'b0;
        end else if (load) begin
            instr_q    <= rom_data;
            instr_pc_q <= pc_q;
            valid_q    <= 1'b1;
            pc_q       <= pc_d;
        end else if (fire) begin
            valid_q <= 1'b0;
        end
    end

    assign rom_addr    = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign halted      = (state_q == HALT);
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch with a combinational ROM model.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] rom_addr;
    logic [20:0] rom_data;
    logic [20:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_addr = '0;
    logic        halt_req = 1'b0;
    logic        halted;
    logic        jmp9 = 1'b0;
    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_q[$];

    instr_fetch dut (
        .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr), .halt_req(halt_req), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] rom_fn(input logic [15:0] a);
        return (jmp9 && a == 16'd9) ? 21'b010010000000000001001 : {5'b00000, a};
    endfunction

    assign rom_data = rom_fn(rom_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every accepted, non-discarded transfer must match the next expected address.
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready && !redirect_valid) begin
            if (exp_q.size() == 0) chk("sb_unexpected", 32'(instr_pc), 32'hFFFF_FFFF);
            else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk("sb_pc", 32'(instr_pc), 32'(e));
                chk("sb_instr", 32'(instr), 32'(rom_fn(e)));
            end
        end
    end

    initial begin
        step();
        step();
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_addr", 32'(rom_addr), 0);
        chk("rst_instr", 32'(instr), 0);
        for (int i = 0; i < 6; i++) exp_q.push_back(16'(i));
        rst = 1'b0;
        instr_ready = 1'b1;
        step();
        chk("first_valid", 32'(instr_valid), 1);
        for (int i = 0; i < 5; i++) step();
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_pc", 32'(instr_pc), 5);
            chk("bp_addr", 32'(rom_addr), 6);
            chk("bp_valid", 32'(instr_valid), 1);
        end
        exp_q.push_back(16'd6);
        exp_q.push_back(16'd7);
        instr_ready = 1'b1;
        step();
        step();
        step();
        chk("pre_redir_pc", 32'(instr_pc), 8);
        redirect_valid = 1'b1;
        redirect_addr = 16'h0040;
        exp_q.push_back(16'h0040);
        exp_q.push_back(16'h0041);
        step();
        redirect_valid = 1'b0;
        chk("redir_bubble", 32'(instr_valid), 0);
        chk("redir_addr", 32'(rom_addr), 32'h40);
        step();
        step();
        step();
        redirect_valid = 1'b1;
        redirect_addr = 16'hFFFE;
        exp_q.push_back(16'hFFFE);
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0000);
        step();
        redirect_valid = 1'b0;
        chk("wrap_bubble", 32'(instr_valid), 0);
        for (int i = 0; i < 4; i++) step();
        chk("wrap_pc1", 32'(instr_pc), 1);
        instr_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr = 16'd7;
        step();
        redirect_valid = 1'b0;
        step();
        chk("pre_halt_pc", 32'(instr_pc), 7);
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        chk("halt_on", 32'(halted), 1);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("halt_hold_pc", 32'(instr_pc), 7);
            chk("halt_hold_valid", 32'(instr_valid), 1);
        end
        exp_q.push_back(16'd7);
        instr_ready = 1'b1;
        halt_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("halt_drained", 32'(instr_valid), 0);
            chk("halt_addr", 32'(rom_addr), 8);
            chk("halt_stay", 32'(halted), 1);
        end
        halt_req = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr = 16'd2;
        exp_q.push_back(16'd2);
        step();
        redirect_valid = 1'b0;
        chk("unhalt", 32'(halted), 0);
        chk("unhalt_bubble", 32'(instr_valid), 0);
        step();
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        chk("halt2_on", 32'(halted), 1);
        chk("halt2_valid", 32'(instr_valid), 0);
        chk("halt2_noload", 32'(rom_addr), 3);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_halt", 32'(halted), 0);
        chk("rst_halt_valid", 32'(instr_valid), 0);
        chk("rst_halt_addr", 32'(rom_addr), 0);
        exp_q.push_back(16'd0);
        exp_q.push_back(16'd1);
        step();
        step();
        step();
        jmp9 = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr = 16'd9;
        for (int i = 0; i < 4; i++) begin
`ifdef FETCH_JMP_PREDECODE_EN
            exp_q.push_back(16'd9);
`else
            exp_q.push_back(16'(9 + i));
`endif
        end
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("jmp_valid", 32'(instr_valid), 1);
        end
        #5;
        instr_ready = 1'b0;
        step();
        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
